// File: rtl/cnn_mem_reader.sv
// Read-side sequencer for the CNN layer memories: streams `length` bytes from a
// synchronous-read byte RAM onto a valid/ready byte stream at one byte per cycle.
module cnn_mem_reader #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_BITS = 4,
    parameter int unsigned LEN_BITS  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [ADDR_BITS-1:0] base_addr_i,
    input  logic [LEN_BITS-1:0]  length_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 ram_re_o,
    output logic [ADDR_BITS-1:0] ram_addr_o,
    input  logic [7:0]           ram_rdata_i,
    output logic [7:0]           m_data_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic                 m_last_o
);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    localparam logic [ADDR_BITS-1:0] AddrLast = ADDR_BITS'(DEPTH - 1);
    localparam logic [ADDR_BITS-1:0] AddrOne  = ADDR_BITS'(1);
    localparam logic [LEN_BITS-1:0]  LenOne   = LEN_BITS'(1);

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [LEN_BITS-1:0]  len_q, len_d;
    logic [LEN_BITS-1:0]  issued_q, issued_d;
    logic [LEN_BITS-1:0]  sent_q, sent_d;
    logic                 inflight_q, inflight_d;
    logic [7:0]           buf_q [2];
    logic [7:0]           buf_d [2];
    logic                 rd_ptr_q, rd_ptr_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic [1:0]           count_q, count_d;

    logic       active, cancel, hs, last_hs, push, pop;
    logic [1:0] pending;

    always_comb begin
        active     = (state_q == StRun) || (state_q == StFlush);
        cancel     = active && abort_i;
        pending    = count_q + {1'b0, inflight_q};
        busy_o     = active;
        done_o     = (state_q == StDone);
        // Credit covers both buffered bytes and the read whose data lands next cycle.
        ram_re_o   = (state_q == StRun) && !abort_i && (issued_q != len_q) && (pending < 2'd2);
        ram_addr_o = addr_q;
        m_valid_o  = (count_q != 2'd0) || inflight_q;
        // An empty buffer forwards the arriving RAM byte so the first beat costs no extra cycle.
        if (count_q != 2'd0) begin
            m_data_o = buf_q[rd_ptr_q];
        end else if (inflight_q) begin
            m_data_o = ram_rdata_i;
        end else begin
            m_data_o = 8'h00;
        end
        m_last_o = m_valid_o && (sent_q == (len_q - LenOne));
        hs       = m_valid_o && m_ready_i;
        last_hs  = hs && m_last_o;
        push     = inflight_q && !((count_q == 2'd0) && hs);
        pop      = hs && (count_q != 2'd0);
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        issued_d   = issued_q;
        sent_d     = sent_q;
        inflight_d = ram_re_o;
        buf_d      = buf_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q + {1'b0, push} - {1'b0, pop};

        if (ram_re_o) begin
            issued_d = issued_q + LenOne;
            addr_d   = (addr_q == AddrLast) ? '0 : addr_q + AddrOne;
        end
        if (hs) begin
            sent_d = sent_q + LenOne;
        end
        if (push) begin
            buf_d[wr_ptr_q] = ram_rdata_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        // Dropping inflight here discards the byte still returning from the RAM.
        if (cancel) begin
            inflight_d = 1'b0;
            count_d    = 2'd0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    len_d    = length_i;
                    addr_d   = base_addr_i;
                    issued_d = '0;
                    sent_d   = '0;
                    state_d  = (length_i == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (last_hs) begin
                    state_d = StDone;
                end else if (issued_d == len_q) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (last_hs) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            inflight_q <= 1'b0;
            buf_q[0]   <= 8'h00;
            buf_q[1]   <= 8'h00;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            sent_q     <= sent_d;
            inflight_q <= inflight_d;
            buf_q      <= buf_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_cnn_mem_reader.sv
// Bench for cnn_mem_reader: RAM model, byte-queue stream model with per-cycle monitor,
// and directed transfers with literal expectations.
module tb_cnn_mem_reader;

    logic       clk = 1'b0;
    logic       reset, start, abort, m_ready;
    logic [3:0] base_addr;
    logic [4:0] length;
    logic       busy, done, ram_re, m_valid, m_last;
    logic [3:0] ram_addr;
    logic [7:0] ram_rdata, m_data;

    always #5 clk = ~clk;

    cnn_mem_reader #(.DEPTH(16), .ADDR_BITS(4), .LEN_BITS(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start),
        .base_addr_i(base_addr),
        .length_i   (length),
        .abort_i    (abort),
        .busy_o     (busy),
        .done_o     (done),
        .ram_re_o   (ram_re),
        .ram_addr_o (ram_addr),
        .ram_rdata_i(ram_rdata),
        .m_data_o   (m_data),
        .m_valid_o  (m_valid),
        .m_ready_i  (m_ready),
        .m_last_o   (m_last)
    );

    logic [7:0] mem [16];
    initial for (int i = 0; i < 16; i++) mem[i] = 8'(16 + i);

    always @(posedge clk) begin
        if (ram_re) ram_rdata <= mem[ram_addr];
        else        ram_rdata <= 8'hEE;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stream model state for the current transfer.
    int         t_start, cur_base, cur_len, issued_cnt, sent_cnt, done_cnt;
    int         first_rel, last_rel, done_rel;
    logic [7:0] exp_q [$];
    logic [7:0] got [$];
    logic [7:0] want [$];
    int         addrs [$];
    int         want_a [$];
    logic       stalled = 1'b0;
    logic [7:0] st_data;
    logic       st_last;
    logic       pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (ram_re) begin
                chk("ram_addr", 32'(ram_addr), 32'((cur_base + issued_cnt) % 16));
                chk("re_credit", 32'((issued_cnt - sent_cnt) < 2), 32'd1);
                chk("re_within_len", 32'(issued_cnt < cur_len), 32'd1);
                addrs.push_back(int'(ram_addr));
                issued_cnt++;
            end
            chk("m_last", 32'(m_last), 32'(m_valid && exp_q.size() == 1));
            if (stalled && m_valid) begin
                chk("stall_data", 32'(m_data), 32'(st_data));
                chk("stall_last", 32'(m_last), 32'(st_last));
            end
            if (m_valid && m_ready) begin
                chk("beat_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
                got.push_back(m_data);
                if (first_rel < 0) first_rel = cyc - t_start;
                if (m_last) last_rel = cyc - t_start;
                sent_cnt++;
            end
            stalled = m_valid && !m_ready;
            st_data = m_data;
            st_last = m_last;
            if (done) begin
                chk("done_all_sent", 32'(exp_q.size()), 32'd0);
                chk("done_busy", 32'(busy), 32'd0);
                done_cnt++;
                done_rel = cyc - t_start;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic go(input logic [3:0] b, input logic [4:0] n);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; length = n;
        t_start = cyc; cur_base = int'(b); cur_len = int'(n);
        issued_cnt = 0; sent_cnt = 0; done_cnt = 0;
        first_rel = -1; last_rel = -1; done_rel = -1;
        exp_q.delete(); got.delete(); addrs.delete();
        for (int i = 0; i < int'(n); i++) exp_q.push_back(mem[(int'(b) + i) % 16]);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit bp, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (bp) m_ready = pat[k % 6];
            if (done_cnt > 0) break;
        end
        chk("done_seen", 32'(done_cnt > 0), 32'd1);
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("single_done", 32'(done_cnt), 32'd1);
    endtask

    task automatic chk_got(input string nm);
        chk({nm, "_count"}, 32'(got.size()), 32'(want.size()));
        for (int i = 0; i < want.size() && i < got.size(); i++) chk(nm, 32'(got[i]), 32'(want[i]));
    endtask

    task automatic interrupt(input bit use_reset);
        go(4'd0, 5'd10);
        repeat (4) @(posedge clk);
        #1;
        if (use_reset) reset = 1'b1; else abort = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("cut_m_valid", 32'(m_valid), 32'd0);
        chk("cut_busy", 32'(busy), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("cut_no_done", 32'(done_cnt), 32'd0);
        go(4'd0, 5'd2);
        wait_done(1'b0, 20);
        want = '{8'h10, 8'h11};
        chk_got("after_cut");
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b1;
        base_addr = '0; length = '0;
        t_start = 0; cur_base = 0; cur_len = 0; issued_cnt = 0; sent_cnt = 0; done_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ram_re", 32'(ram_re), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic stream
        go(4'd2, 5'd4);
        wait_done(1'b0, 20);
        want = '{8'h12, 8'h13, 8'h14, 8'h15};
        chk_got("basic_bytes");
        chk("basic_first_cycle", 32'(first_rel), 32'd2);
        chk("basic_last_cycle", 32'(last_rel), 32'd5);
        chk("basic_done_cycle", 32'(done_rel), 32'd6);

        // Wrap-around
        go(4'd14, 5'd4);
        wait_done(1'b0, 20);
        want = '{8'h1E, 8'h1F, 8'h10, 8'h11};
        chk_got("wrap_bytes");
        want_a = '{14, 15, 0, 1};
        chk("wrap_addr_count", 32'(addrs.size()), 32'd4);
        for (int i = 0; i < 4 && i < addrs.size(); i++)
            chk("wrap_addr", 32'(addrs[i]), 32'(want_a[i]));

        // Backpressure
        go(4'd0, 5'd8);
        wait_done(1'b1, 80);
        want = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        chk_got("bp_bytes");

        // Zero length
        go(4'd3, 5'd0);
        wait_done(1'b0, 10);
        chk("zero_done_cycle", 32'(done_rel), 32'd1);
        chk("zero_no_beats", 32'(got.size()), 32'd0);
        chk("zero_no_reads", 32'(addrs.size()), 32'd0);

        // Full length
        go(4'd0, 5'd16);
        wait_done(1'b0, 40);
        want.delete();
        for (int i = 0; i < 16; i++) want.push_back(8'(8'h10 + i));
        chk_got("full_bytes");
        chk("full_last_byte", 32'(got.size() == 16 ? got[15] : 8'h00), 32'h1F);
        chk("full_last_cycle", 32'(last_rel), 32'd17);
        chk("full_done_cycle", 32'(done_rel), 32'd18);

        interrupt(1'b0);
        interrupt(1'b1);

        // Ignored start while busy
        go(4'd0, 5'd4);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 4'd7; length = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1'b0, 20);
        want = '{8'h10, 8'h11, 8'h12, 8'h13};
        chk_got("ignored_start");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
